// File: rtl/rng_sample_sequencer.sv
// rng_sample_sequencer: control FSM turning the raw RNG datapath into samples.
// Restart -> uniform capture -> float convert -> table lookup -> PWL eval -> out.
module rng_sample_sequencer #(
    parameter int BX         = 32,
    parameter int BY         = 16,
    parameter int K          = 4,
    parameter int MANT_BW    = 20,
    parameter int EXP_BW     = 10,
    parameter int G_OCT      = 8,
    parameter int D_OCT      = 8,
    parameter int LOOKUP_LAT = 1,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              urng_rst,
    input  logic              urng_done,
    input  logic [BX-1:0]     urng_word,
    output logic [BX-1:0]     uword,
    output logic              conv_start,
    input  logic              conv_done,
    input  logic [BX-1:0]     floating,
    output logic              lut_en,
    output logic [EXP_BW:0]   section_addr,
    output logic [K-1:0]      subsection_addr,
    input  logic [BY-1:0]     c0,
    input  logic [BY-1:0]     c1,
    output logic [BY-1:0]     sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              err_timeout
);

    localparam int XW  = MANT_BW - K;
    localparam int SW  = EXP_BW + 1;
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam int LCW = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;

    localparam logic [WCW-1:0]    W_LAST = WCW'(TIMEOUT - 1);
    localparam logic [WCW-1:0]    W_ONE  = WCW'(1);
    localparam logic [LCW-1:0]    L_LAST = LCW'(LOOKUP_LAT - 1);
    localparam logic [LCW-1:0]    L_ONE  = LCW'(1);
    localparam logic [EXP_BW-1:0] G_MAX  = EXP_BW'(G_OCT - 1);
    localparam logic [EXP_BW-1:0] D_MAX  = EXP_BW'(D_OCT - 1);
    localparam logic [SW-1:0]     D_BASE = SW'(G_OCT);
    localparam logic [BY-1:0]     Y_SAT  = BY'(2 ** (BY - 1) - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RESTART = 3'd1;
    localparam logic [2:0] S_WAIT_U  = 3'd2;
    localparam logic [2:0] S_CONV    = 3'd3;
    localparam logic [2:0] S_LOOKUP  = 3'd4;
    localparam logic [2:0] S_EVAL    = 3'd5;
    localparam logic [2:0] S_OUT     = 3'd6;

    logic [2:0]        state;
    logic [WCW-1:0]    wait_cnt;
    logic [LCW-1:0]    lat_cnt;
    logic              fword_symm;
    logic [XW-1:0]     fword_x;

    logic [EXP_BW-1:0] f_exp;
    logic [EXP_BW-1:0] f_oct;
    logic [SW-1:0]     sec_next;
    logic [BY-1:0]     p;
    logic [BY:0]       m_sum;
    logic [BY-1:0]     m_sat;
    logic [BY-1:0]     y_next;

    // Section is the clamped octave, offset past the growing part when part=1.
    always_comb begin
        f_exp = floating[MANT_BW +: EXP_BW];
        if (floating[BX-2]) begin
            f_oct    = (f_exp > D_MAX) ? D_MAX : f_exp;
            sec_next = {1'b0, f_oct} + D_BASE;
        end else begin
            f_oct    = (f_exp > G_MAX) ? G_MAX : f_exp;
            sec_next = {1'b0, f_oct};
        end
    end

    always_comb begin
        p      = BY'(({{XW{1'b0}}, c1} * {{BY{1'b0}}, fword_x}) >> XW);
        m_sum  = {1'b0, c0} + {1'b0, p};
        m_sat  = (m_sum > {1'b0, Y_SAT}) ? Y_SAT : m_sum[BY-1:0];
        y_next = fword_symm ? -m_sat : m_sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            wait_cnt        <= '0;
            lat_cnt         <= '0;
            fword_symm      <= 1'b0;
            fword_x         <= '0;
            uword           <= '0;
            urng_rst        <= 1'b0;
            conv_start      <= 1'b0;
            lut_en          <= 1'b0;
            section_addr    <= '0;
            subsection_addr <= '0;
            sample          <= '0;
            sample_valid    <= 1'b0;
            busy            <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            urng_rst   <= 1'b0;
            conv_start <= 1'b0;
            lut_en     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_RESTART;
                        urng_rst <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_RESTART: begin
                    state    <= S_WAIT_U;
                    wait_cnt <= '0;
                end
                S_WAIT_U: begin
                    if (urng_done) begin
                        uword      <= urng_word;
                        conv_start <= 1'b1;
                        state      <= S_CONV;
                    end else if (wait_cnt == W_LAST) begin
                        err_timeout <= 1'b1;
                        urng_rst    <= 1'b1;
                        state       <= S_RESTART;
                    end else begin
                        wait_cnt <= wait_cnt + W_ONE;
                    end
                end
                S_CONV: begin
                    if (conv_done) begin
                        fword_symm      <= floating[BX-1];
                        fword_x         <= floating[XW-1:0];
                        section_addr    <= sec_next;
                        subsection_addr <= floating[MANT_BW-1 -: K];
                        lut_en          <= 1'b1;
                        lat_cnt         <= '0;
                        state           <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lat_cnt == L_LAST) begin
                        state <= S_EVAL;
                    end else begin
                        lat_cnt <= lat_cnt + L_ONE;
                    end
                end
                S_EVAL: begin
                    sample       <= y_next;
                    sample_valid <= 1'b1;
                    state        <= S_OUT;
                end
                S_OUT: begin
                    if (sample_ready) begin
                        sample_valid <= 1'b0;
                        if (run) begin
                            state    <= S_RESTART;
                            urng_rst <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    sample_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
